// File: rtl/mario_pkg.sv
// Shared definitions for the bitmap generator datapath.
// Holds the owner encoding used to tag ROM reads in flight, the default
// sprite/tile ROM geometry, and the owner pipeline slot type.
package mario_pkg;

  // Owner tag carried alongside each ROM read so the returned word can be
  // routed to the requester that issued it.
  localparam logic OWN_BG  = 1'b0;
  localparam logic OWN_SPR = 1'b1;

  // Default sprite/tile ROM geometry, reused by bitmap_gen.
  localparam int ROM_AW = 12;
  localparam int ROM_DW = 8;

  // One slot of the owner pipeline: whether a read is in flight and for whom.
  typedef struct packed {
    logic valid;
    logic owner;
  } owner_slot_t;

endpackage

// File: rtl/rom_arbiter_wait_counter.sv
// wait_counter: per-requester aging counter for the ROM arbiter.
// Counts consecutive cycles a requester has been refused and flags when the
// count reaches MAX_WAIT so the arbiter can force that requester to win.
//
// Ports:
//   i_clk      system clock
//   i_reset    asynchronous, active-low reset
//   i_req      requester is asking for the ROM this cycle
//   i_ack      requester was granted this cycle
//   o_at_max   refusal count has reached MAX_WAIT
module wait_counter
  import mario_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_req,
  input  logic i_ack,
  output logic o_at_max
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] r_count;

  // A grant or a withdrawn request starts the aging over; a refused request
  // ages by one and saturates so the forced win stays pending until served.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (!i_req || i_ack) begin
      r_count <= '0;
    end else if (r_count != MAX_CNT) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_max = (r_count == MAX_CNT);

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous single-port sprite/tile ROM between the
// background tile fetcher and the sprite fetcher. At most one read is issued
// per cycle; each returned word is routed back to the requester that issued
// it. Active video favours the background path, blanking favours sprites, and
// an aging counter per requester bounds how long the loser can be refused.
//
// Ports:
//   i_clk                      system clock
//   i_reset                    asynchronous, active-low reset
//   i_video_on                 high during the visible area
//   i_bg_req / i_bg_addr       background fetch request and address
//   o_bg_ack                   background request accepted this cycle
//   o_bg_valid / o_bg_data     one-cycle pulse with the returned word
//   i_spr_req ... o_spr_data   same set for the sprite fetcher
//   o_rom_en / o_rom_addr      ROM read enable and address
//   i_rom_data                 ROM output, valid one cycle after o_rom_en
module rom_arbiter
  import mario_pkg::*;
#(
  parameter int AW       = ROM_AW,
  parameter int DW       = ROM_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_video_on,
  input  logic          i_bg_req,
  input  logic [AW-1:0] i_bg_addr,
  output logic          o_bg_ack,
  output logic          o_bg_valid,
  output logic [DW-1:0] o_bg_data,
  input  logic          i_spr_req,
  input  logic [AW-1:0] i_spr_addr,
  output logic          o_spr_ack,
  output logic          o_spr_valid,
  output logic [DW-1:0] o_spr_data,
  output logic          o_rom_en,
  output logic [AW-1:0] o_rom_addr,
  input  logic [DW-1:0] i_rom_data
);

  logic          w_bgAtMax;
  logic          w_sprAtMax;
  logic          w_bgWins;
  logic          w_sprWins;
  logic          w_romEn;
  owner_slot_t   r_stage1;
  owner_slot_t   r_stage2;
  logic [DW-1:0] r_bgData;
  logic [DW-1:0] r_sprData;

  wait_counter #(.MAX_WAIT(MAX_WAIT)) u_bgWait (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req    (i_bg_req),
    .i_ack    (w_bgWins),
    .o_at_max (w_bgAtMax)
  );

  wait_counter #(.MAX_WAIT(MAX_WAIT)) u_sprWait (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req    (i_spr_req),
    .i_ack    (w_sprWins),
    .o_at_max (w_sprAtMax)
  );

  // Winner selection. Grants are suppressed while reset is held so no read
  // can be issued into a pipeline that is being cleared. An aged-out loser
  // only overrides the video-based priority when it alone has aged out.
  always_comb begin
    w_bgWins  = 1'b0;
    w_sprWins = 1'b0;
    if (i_reset) begin
      if (i_bg_req && !i_spr_req) begin
        w_bgWins = 1'b1;
      end else if (i_spr_req && !i_bg_req) begin
        w_sprWins = 1'b1;
      end else if (i_bg_req && i_spr_req) begin
        if (w_bgAtMax && !w_sprAtMax) begin
          w_bgWins = 1'b1;
        end else if (w_sprAtMax && !w_bgAtMax) begin
          w_sprWins = 1'b1;
        end else if (i_video_on) begin
          w_bgWins = 1'b1;
        end else begin
          w_sprWins = 1'b1;
        end
      end
    end
  end

  assign w_romEn    = w_bgWins | w_sprWins;
  assign o_bg_ack   = w_bgWins;
  assign o_spr_ack  = w_sprWins;
  assign o_rom_en   = w_romEn;
  assign o_rom_addr = w_bgWins  ? i_bg_addr  :
                      w_sprWins ? i_spr_addr : '0;

  // Owner pipeline. Stage 1 lines up with the cycle the ROM drives its word;
  // stage 2 lines up with the cycle the captured word is presented as valid.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stage1 <= '0;
      r_stage2 <= '0;
    end else begin
      r_stage1.valid <= w_romEn;
      r_stage1.owner <= w_sprWins ? OWN_SPR : OWN_BG;
      r_stage2       <= r_stage1;
    end
  end

  // Only the owner's data register loads; the other keeps its last word.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_bgData  <= '0;
      r_sprData <= '0;
    end else if (r_stage1.valid) begin
      if (r_stage1.owner == OWN_SPR) begin
        r_sprData <= i_rom_data;
      end else begin
        r_bgData <= i_rom_data;
      end
    end
  end

  assign o_bg_valid  = r_stage2.valid && (r_stage2.owner == OWN_BG);
  assign o_spr_valid = r_stage2.valid && (r_stage2.owner == OWN_SPR);
  assign o_bg_data   = r_bgData;
  assign o_spr_data  = r_sprData;

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter with a synchronous ROM model whose contents are
// derived from the address. Expected return words are queued per requester
// when a transfer happens and popped when the matching valid pulse appears.
module tb_rom_arbiter;

  logic        clk;
  logic        reset;
  logic        videoOn;
  logic        bgReq;
  logic [11:0] bgAddr;
  logic        bgAck;
  logic        bgValid;
  logic [7:0]  bgData;
  logic        sprReq;
  logic [11:0] sprAddr;
  logic        sprAck;
  logic        sprValid;
  logic [7:0]  sprData;
  logic        romEn;
  logic [11:0] romAddr;
  logic [7:0]  romData;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t bgQ[$];
  exp_t sprQ[$];
  exp_t eBg;
  exp_t eSpr;

  rom_arbiter #(.AW(12), .DW(8), .MAX_WAIT(4)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_video_on  (videoOn),
    .i_bg_req    (bgReq),
    .i_bg_addr   (bgAddr),
    .o_bg_ack    (bgAck),
    .o_bg_valid  (bgValid),
    .o_bg_data   (bgData),
    .i_spr_req   (sprReq),
    .i_spr_addr  (sprAddr),
    .o_spr_ack   (sprAck),
    .o_spr_valid (sprValid),
    .o_spr_data  (sprData),
    .o_rom_en    (romEn),
    .o_rom_addr  (romAddr),
    .i_rom_data  (romData)
  );

  // ROM contents chosen so that address 0x010 holds 0xA5.
  function automatic logic [7:0] romModel(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'hB5;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port ROM: word appears the cycle after the read enable.
  always @(posedge clk) begin
    if (romEn) romData <= romModel(romAddr);
  end

  // Scoreboard: check returned words against queued expectations, then queue
  // new expectations from transfers seen this cycle.
  always @(negedge clk) begin
    if (bgValid) begin
      compared++;
      if (bgQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL bg_valid_unexpected: got valid=1 data=%h, required valid=0", bgData);
      end else begin
        eBg = bgQ.pop_front();
        if (bgData !== eBg.data || cyc != eBg.cyc + 2) begin
          mismatched++;
          $display("[TB] FAIL bg_return: got data=%h cycle=%0d, required data=%h cycle=%0d",
                   bgData, cyc, eBg.data, eBg.cyc + 2);
        end
      end
    end
    if (sprValid) begin
      compared++;
      if (sprQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL spr_valid_unexpected: got valid=1 data=%h, required valid=0", sprData);
      end else begin
        eSpr = sprQ.pop_front();
        if (sprData !== eSpr.data || cyc != eSpr.cyc + 2) begin
          mismatched++;
          $display("[TB] FAIL spr_return: got data=%h cycle=%0d, required data=%h cycle=%0d",
                   sprData, cyc, eSpr.data, eSpr.cyc + 2);
        end
      end
    end
    if (bgAck)  bgQ.push_back('{data: romModel(bgAddr), cyc: cyc});
    if (sprAck) sprQ.push_back('{data: romModel(sprAddr), cyc: cyc});
  end

  // Drives one cycle of requester inputs just after the rising edge.
  task automatic applyStimulus(input logic br, input logic [11:0] ba,
                               input logic sr, input logic [11:0] sa,
                               input logic vid);
    @(posedge clk);
    #1;
    bgReq   = br;
    bgAddr  = ba;
    sprReq  = sr;
    sprAddr = sa;
    videoOn = vid;
  endtask

  task automatic test_reset;
    applyStimulus(1'b1, 12'h0AB, 1'b1, 12'h0CD, 1'b1);
    @(negedge clk);
    compared++;
    if ({bgAck, sprAck, romEn, bgValid, sprValid} !== 5'b0 || romAddr !== 12'h0 ||
        bgData !== 8'h0 || sprData !== 8'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got ack=%b%b en=%b addr=%h valid=%b%b data=%h/%h, required all zero",
               bgAck, sprAck, romEn, romAddr, bgValid, sprValid, bgData, sprData);
    end
    applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bg_alone;
    applyStimulus(1'b1, 12'h010, 1'b0, 12'h0, 1'b1);
    @(negedge clk);
    compared++;
    if ({bgAck, sprAck, romEn} !== 3'b101 || romAddr !== 12'h010) begin
      mismatched++;
      $display("[TB] FAIL bg_alone_issue: got ack=%b%b en=%b addr=%h, required ack=10 en=1 addr=010",
               bgAck, sprAck, romEn, romAddr);
    end
    applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 1'b1);
    @(negedge clk);
    compared++;
    if (bgValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bg_alone_early: got bg_valid=%b, required 0", bgValid);
    end
    applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 1'b1);
    @(negedge clk);
    compared++;
    if (bgValid !== 1'b1 || bgData !== 8'hA5 || sprValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bg_alone_return: got bg_valid=%b bg_data=%h spr_valid=%b, required 1 A5 0",
               bgValid, bgData, sprValid);
    end
    applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 1'b1);
    @(negedge clk);
    compared++;
    if (bgValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bg_alone_pulse: got bg_valid=%b, required 0", bgValid);
    end
  endtask

  task automatic test_both_single(input logic vid);
    logic [1:0]  expAck;
    logic [11:0] expAddr;
    expAck  = vid ? 2'b10 : 2'b01;
    expAddr = vid ? 12'h001 : 12'h002;
    applyStimulus(1'b1, 12'h001, 1'b1, 12'h002, vid);
    @(negedge clk);
    compared++;
    if ({bgAck, sprAck} !== expAck || romAddr !== expAddr) begin
      mismatched++;
      $display("[TB] FAIL both_first(video=%b): got ack=%b addr=%h, required ack=%b addr=%h",
               vid, {bgAck, sprAck}, romAddr, expAck, expAddr);
    end
    applyStimulus(~vid, 12'h001, vid, 12'h002, vid);
    @(negedge clk);
    expAck  = ~expAck;
    expAddr = vid ? 12'h002 : 12'h001;
    compared++;
    if ({bgAck, sprAck} !== expAck || romAddr !== expAddr) begin
      mismatched++;
      $display("[TB] FAIL both_second(video=%b): got ack=%b addr=%h, required ack=%b addr=%h",
               vid, {bgAck, sprAck}, romAddr, expAck, expAddr);
    end
    applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, vid);
    repeat (4) @(negedge clk);
  endtask

  // Both held continuously; the favoured side wins 4 times, then the other once.
  task automatic test_contention(input logic vid);
    logic [11:0] ba;
    logic [11:0] sa;
    logic [1:0]  expAck;
    logic [11:0] expAddr;
    ba = 12'h200;
    sa = 12'h300;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, ba, 1'b1, sa, vid);
      @(negedge clk);
      if ((i % 5) != 4) expAck = vid ? 2'b10 : 2'b01;
      else              expAck = vid ? 2'b01 : 2'b10;
      expAddr = expAck[1] ? ba : sa;
      compared++;
      if ({bgAck, sprAck} !== expAck || romAddr !== expAddr) begin
        mismatched++;
        $display("[TB] FAIL contention(video=%b) step %0d: got ack=%b addr=%h, required ack=%b addr=%h",
                 vid, i, {bgAck, sprAck}, romAddr, expAck, expAddr);
      end
      if (bgAck)  ba = ba + 12'h1;
      if (sprAck) sa = sa + 12'h1;
    end
    applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, vid);
    repeat (4) @(negedge clk);
  endtask

  // Sprite gives up after two refusals; its aging must restart from zero.
  task automatic test_abandon;
    logic [11:0] ba;
    logic        sr;
    logic [1:0]  expAck;
    ba = 12'h400;
    for (int i = 0; i < 8; i++) begin
      sr = (i != 2);
      applyStimulus(1'b1, ba, sr, 12'h3F0, 1'b1);
      @(negedge clk);
      expAck = (i == 7) ? 2'b01 : 2'b10;
      compared++;
      if ({bgAck, sprAck} !== expAck) begin
        mismatched++;
        $display("[TB] FAIL abandon step %0d: got ack=%b, required ack=%b", i, {bgAck, sprAck}, expAck);
      end
      if (bgAck) ba = ba + 12'h1;
    end
    applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 12'h100 + 12'(i), 1'b0, 12'h0, 1'b0);
      @(negedge clk);
      compared++;
      if (bgAck !== 1'b1 || romAddr !== 12'h100 + 12'(i)) begin
        mismatched++;
        $display("[TB] FAIL back_to_back %0d: got ack=%b addr=%h, required ack=1 addr=%h",
                 i, bgAck, romAddr, 12'h100 + 12'(i));
      end
    end
    applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midflight;
    applyStimulus(1'b1, 12'h020, 1'b0, 12'h0, 1'b1);
    @(negedge clk);
    compared++;
    if (bgAck !== 1'b1 || romAddr !== 12'h020) begin
      mismatched++;
      $display("[TB] FAIL midflight_issue: got ack=%b addr=%h, required ack=1 addr=020", bgAck, romAddr);
    end
    applyStimulus(1'b1, 12'h020, 1'b0, 12'h0, 1'b1);
    reset = 1'b0;
    bgQ.delete();
    sprQ.delete();
    #2;
    compared++;
    if ({bgAck, sprAck, romEn, bgValid, sprValid} !== 5'b0 || romAddr !== 12'h0 ||
        bgData !== 8'h0 || sprData !== 8'h0) begin
      mismatched++;
      $display("[TB] FAIL midflight_reset: got ack=%b%b en=%b addr=%h valid=%b%b data=%h/%h, required all zero",
               bgAck, sprAck, romEn, romAddr, bgValid, sprValid, bgData, sprData);
    end
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 12'h030, 1'b0, 12'h0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (bgAck !== 1'b1 || romAddr !== 12'h030 || bgValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL release_first: got ack=%b addr=%h valid=%b, required ack=1 addr=030 valid=0",
               bgAck, romAddr, bgValid);
    end
    applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 1'b1);
    @(negedge clk);
    compared++;
    if (bgValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL release_stale: got bg_valid=%b, required 0", bgValid);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_drained;
    compared++;
    if (bgQ.size() != 0 || sprQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drained: got pending bg=%0d spr=%0d, required 0/0", bgQ.size(), sprQ.size());
    end
  endtask

  initial begin
    reset   = 1'b0;
    videoOn = 1'b1;
    bgReq   = 1'b0;
    bgAddr  = 12'h0;
    sprReq  = 1'b0;
    sprAddr = 12'h0;
    romData = 8'h0;
    test_reset();
    test_bg_alone();
    test_drained();
    test_both_single(1'b1);
    test_both_single(1'b0);
    test_drained();
    test_contention(1'b1);
    test_contention(1'b0);
    test_drained();
    test_abandon();
    test_back_to_back();
    test_drained();
    test_reset_midflight();
    test_drained();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion, required completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares one synchronous single-port sprite/tile ROM between the background tile fetcher and the sprite fetcher inside the bitmap generator. Issues at most one ROM read per cycle. Routes each returned word to the requester that issued it. Active video favours the background path; blanking favours sprites. An aging counter guarantees the losing requester is served within a bounded number of cycles.

## Interface
Parameters:
- AW, 12, ROM address width
- DW, 8, ROM data width (matches 8-bit rgb)
- MAX_WAIT, 4, cycles a requester may be refused before it is forced to win (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- video_on  in  1  high during visible area (from sync generator)
- bg_req  in  1  background fetch request
- bg_addr  in  AW  background read address
- bg_ack  out  AW-independent 1  request accepted this cycle
- bg_valid  out  1  one-cycle pulse, bg_data valid
- bg_data  out  DW  returned word
- spr_req, spr_addr, spr_ack, spr_valid, spr_data  same as bg_*, for the sprite fetcher
- rom_en  out  1  ROM read enable
- rom_addr  out  AW  ROM address
- rom_data  in  DW  ROM output, valid one cycle after rom_en

## Operation
- A transfer occurs at the rising edge when req and ack are both high. A requester holds addr stable while req is high. It may present a new addr in the cycle after ack. Holding req continuously allows one transfer per cycle.
- Arbitration is combinational within the cycle. Exactly one ack at most; rom_en = bg_ack | spr_ack; rom_addr = winner's addr. When no ack is asserted, rom_addr = 0.
- Winner selection, in order:
  - Only one req high: that requester wins.
  - Both high and exactly one wait counter == MAX_WAIT: that requester wins.
  - Otherwise, default priority: video_on=1 gives bg the win; video_on=0 gives spr the win.
- Wait counters (one per requester, width clog2(MAX_WAIT+1)):
  - req & ~ack: increment, saturating at MAX_WAIT.
  - ack, or req low: clear to 0.
- Return path:
  - A 2-stage owner pipeline records {valid, owner} at each transfer.
  - In the cycle after a transfer, rom_data is captured into the owner's data register, and that owner's valid pulses in the following cycle.
  - The non-owner's data register holds its previous value.
- A requester dropping req before ack is legal. No access is issued and its counter clears.
- A video_on change takes effect on the same cycle's arbitration; in-flight returns are unaffected.

## Timing
- Reset (asynchronous, low): bg_ack/spr_ack/rom_en = 0, rom_addr = 0, *_valid = 0, *_data = 0, counters = 0, owner pipeline empty.
- Latency: transfer at edge E0 → ROM data at E1 → *_valid high and *_data stable in the cycle after E1 (2 cycles from acceptance).
- Throughput: 1 read/cycle aggregate. Under continuous contention the favoured requester gets MAX_WAIT consecutive acks, then the other gets 1.
- Reset mid-operation discards in-flight reads. No *_valid is asserted after release for accesses accepted before reset.
- Reset release: the first ack is possible in the first cycle reset is high.

## Structure
- Shared package `mario_pkg`: owner encoding constants OWN_BG=1'b0 and OWN_SPR=1'b1, plus the default AW/DW localparams reused by bitmap_gen.
- One natural sub-module: `wait_counter` (saturating counter, inputs req/ack, output at_max), instantiated twice.
- The arbiter and owner pipeline stay in rom_arbiter.

## Test plan
- bg alone, video_on=1, bg_addr=0x010, ROM returns 0xA5:
  - bg_ack and rom_en are high the same cycle, rom_addr=0x010.
  - bg_valid pulses 2 cycles later with bg_data=0xA5.
  - spr_valid stays 0.
- Both single-shot requests, video_on=1, bg 0x001 / spr 0x002:
  - bg is acked in cycle 0, spr in cycle 1.
  - The valids arrive in cycles 2 and 3 with the correct words.
- Same stimulus with video_on=0: spr is acked first, bg second.
- Both req held continuously, video_on=1, MAX_WAIT=4:
  - The ack sequence is bg,bg,bg,bg,spr repeating.
  - Each data word returns to the correct owner, checked against a ROM model with addr-derived contents.
- Back-to-back bg with incrementing addresses 0x100–0x107: 8 consecutive acks and 8 consecutive bg_valid pulses in address order.
- Assert reset one cycle after a transfer at 0x020:
  - All outputs go to 0 immediately.
  - No bg_valid after release.
  - A fresh request after release is served normally.
